// File: rtl/nios_system_pio_pkg.sv
// Shared constants and parameter checks for the multi-channel PIO bank.
// Register offsets are the low two bits of the word address.
package nios_system_pio_pkg;

  localparam logic [1:0] PIO_OFF_DATA    = 2'd0;
  localparam logic [1:0] PIO_OFF_SET     = 2'd1;
  localparam logic [1:0] PIO_OFF_CLR     = 2'd2;
  localparam logic [1:0] PIO_OFF_TIMEOUT = 2'd3;

  function automatic bit pio_params_ok(
    input int width,
    input int channels,
    input int timer_w
  );
    return (width >= 1) && (width <= 32) &&
           (channels >= 1) && (channels <= 16) &&
           (timer_w >= 1) && (timer_w <= 32);
  endfunction

endpackage

// File: rtl/nios_system_pio_channel.sv
// One PIO output channel: data word, set/clear writes and a one-shot
// countdown that clears the word and pulses expired on 1->0.
module nios_system_pio_channel
  import nios_system_pio_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int TIMER_W = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               wr_data,
  input  logic               wr_set,
  input  logic               wr_clr,
  input  logic               wr_timeout,
  input  logic [WIDTH-1:0]   data_in,
  input  logic [TIMER_W-1:0] timeout_in,
  output logic [WIDTH-1:0]   data,
  output logic [TIMER_W-1:0] count,
  output logic               expired
);

  logic             fire;
  logic [WIDTH-1:0] base;

  // A TIMEOUT write in the final cycle replaces the pending expiry.
  assign fire = (count == TIMER_W'(1)) && !wr_timeout;
  assign base = fire ? '0 : data;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      data    <= '0;
      count   <= '0;
      expired <= 1'b0;
    end else begin
      expired <= fire;
      if (wr_timeout) begin
        count <= timeout_in;
      end else if (count != '0) begin
        count <= count - TIMER_W'(1);
      end
      unique case (1'b1)
        wr_data: data <= data_in;
        wr_set:  data <= base | data_in;
        wr_clr:  data <= base & ~data_in;
        default: data <= base;
      endcase
    end
  end

endmodule

// File: rtl/nios_system_pio_bank.sv
// Avalon-MM slave with CHANNELS output words: address decode, read mux
// and out_port packing around per-channel register blocks.
module nios_system_pio_bank
  import nios_system_pio_pkg::*;
#(
  parameter  int WIDTH    = 8,
  parameter  int CHANNELS = 4,
  parameter  int TIMER_W  = 16,
  localparam int ADDR_W   = $clog2(CHANNELS) + 2
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [ADDR_W-1:0]         address,
  input  logic                      chipselect,
  input  logic                      write_n,
  input  logic [31:0]               writedata,
  output logic [31:0]               readdata,
  output logic [CHANNELS*WIDTH-1:0] out_port,
  output logic [CHANNELS-1:0]       expired
);

  if (!pio_params_ok(WIDTH, CHANNELS, TIMER_W)) begin : g_bad_params
    $error("nios_system_pio_bank: parameter out of range");
  end

  logic [ADDR_W-1:0]  chan_sel;
  logic [1:0]         off;
  logic               wr;
  logic               unused_bits;
  logic [WIDTH-1:0]   data_q  [CHANNELS];
  logic [TIMER_W-1:0] count_q [CHANNELS];

  assign chan_sel    = address >> 2;
  assign off         = address[1:0];
  assign wr          = chipselect && !write_n;
  assign unused_bits = ^writedata;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic hit;
    assign hit = wr && (chan_sel == ADDR_W'(c));

    nios_system_pio_channel #(
      .WIDTH   (WIDTH),
      .TIMER_W (TIMER_W)
    ) u_ch (
      .clk        (clk),
      .reset_n    (reset_n),
      .wr_data    (hit && (off == PIO_OFF_DATA)),
      .wr_set     (hit && (off == PIO_OFF_SET)),
      .wr_clr     (hit && (off == PIO_OFF_CLR)),
      .wr_timeout (hit && (off == PIO_OFF_TIMEOUT)),
      .data_in    (writedata[WIDTH-1:0]),
      .timeout_in (writedata[TIMER_W-1:0]),
      .data       (data_q[c]),
      .count      (count_q[c]),
      .expired    (expired[c])
    );

    assign out_port[c*WIDTH +: WIDTH] = data_q[c];
  end

  // Unmapped channel indices fall through to zero.
  always_comb begin
    readdata = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (chan_sel == ADDR_W'(c)) begin
        if (off == PIO_OFF_TIMEOUT) begin
          readdata = 32'(count_q[c]);
        end else begin
          readdata = 32'(data_q[c]);
        end
      end
    end
  end

endmodule
